// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem initiator: FSM state encoding, bus widths
// and the address region decoded by GPIO-style responders.
package iomem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // Top address byte selecting the GPIO responder region.
  localparam logic [7:0] IOMEM_GPIO_REGION = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True when an address falls inside the GPIO region.
  function automatic logic is_gpio_region(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: 8] == IOMEM_GPIO_REGION;
  endfunction

endpackage

// File: rtl/iomem_initiator.sv
// Single-outstanding command -> iomem bus initiator with a response channel
// and a per-transaction timeout on the bus phase.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. cmd_valid/cmd_ready and rsp_valid/rsp_ready follow this rule;
// once rsp_valid rises, rsp_rdata/rsp_err hold until the response transfers.
// On the bus side, iomem_valid stays high with stable addr/wdata/wstrb until
// iomem_ready is sampled high or the timeout expires.
module iomem_initiator
  import iomem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,

  output logic              iomem_valid,
  input  logic              iomem_ready,
  output logic [ADDR_W-1:0] iomem_addr,
  output logic [DATA_W-1:0] iomem_wdata,
  output logic [STRB_W-1:0] iomem_wstrb,
  input  logic [DATA_W-1:0] iomem_rdata,

  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Timer holds the number of completed bus cycles; one extra bit of range
  // keeps TIMEOUT itself representable. A zero TIMEOUT still needs 1 bit.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic          TIMER_ON   = (TIMEOUT > 0);

  state_e            state_q;
  logic [TW-1:0]     timer_q;
  logic              iomem_valid_q;
  logic [ADDR_W-1:0] iomem_addr_q;
  logic [DATA_W-1:0] iomem_wdata_q;
  logic [STRB_W-1:0] iomem_wstrb_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              timer_expired_d;

  // The current cycle is the TIMEOUT-th bus cycle; expiry is taken at its end.
  always_comb begin
    timer_expired_d = TIMER_ON && (timer_q == TIMER_LAST);
  end

  // Transaction FSM with timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      iomem_valid_q <= 1'b0;
      iomem_addr_q  <= '0;
      iomem_wdata_q <= '0;
      iomem_wstrb_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            iomem_addr_q  <= cmd_addr;
            iomem_wdata_q <= cmd_wdata;
            iomem_wstrb_q <= cmd_wstrb;
            iomem_valid_q <= 1'b1;
            timer_q       <= '0;
            state_q       <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (iomem_ready) begin
            // Completion beats a simultaneous expiry.
            rsp_rdata_q   <= iomem_rdata;
            rsp_err_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            iomem_valid_q <= 1'b0;
            state_q       <= ST_RESP;
          end else if (timer_expired_d) begin
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_valid_q   <= 1'b1;
            iomem_valid_q <= 1'b0;
            state_q       <= ST_RESP;
          end else if (timer_q != '1) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output mapping; cmd_ready is combinational and held low during reset.
  always_comb begin
    cmd_ready   = (state_q == ST_IDLE) && resetn;
    busy        = (state_q != ST_IDLE);
    state_dbg   = state_q;
    iomem_valid = iomem_valid_q;
    iomem_addr  = iomem_addr_q;
    iomem_wdata = iomem_wdata_q;
    iomem_wstrb = iomem_wstrb_q;
    rsp_valid   = rsp_valid_q;
    rsp_rdata   = rsp_rdata_q;
    rsp_err     = rsp_err_q;
  end

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed bench for iomem_initiator (TIMEOUT = 8): a table of single
// transactions against a configurable responder, then hand-written
// sequences for response back-pressure and reset mid-transaction.
module tb_iomem_initiator;
  import iomem_pkg::*;

  localparam int TO = 8;
  localparam int M_GPIO  = 0;
  localparam int M_NEVER = 1;
  localparam int M_DELAY = 2;
  localparam logic [31:0] DELAY_RDATA = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_rdata = '0;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Responder model state.
  int          resp_mode = M_GPIO;
  int          resp_delay = 2;
  int          resp_cnt = 0;
  logic [31:0] gpio_reg = '0;

  iomem_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_wstrb(iomem_wstrb), .iomem_rdata(iomem_rdata),
    .busy(busy), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Responder: GPIO-style (ready one cycle after valid, region 0x03 only),
  // never-ready, or ready during the resp_delay-th cycle of iomem_valid.
  always @(posedge clk) begin
    if (!iomem_valid) resp_cnt <= 0;
    iomem_ready <= 1'b0;
    case (resp_mode)
      M_GPIO: begin
        if (iomem_valid && !iomem_ready && iomem_addr[31:24] == IOMEM_GPIO_REGION) begin
          iomem_ready <= 1'b1;
          iomem_rdata <= gpio_reg;
          for (int b = 0; b < 4; b++)
            if (iomem_wstrb[b]) gpio_reg[8*b +: 8] <= iomem_wdata[8*b +: 8];
        end
      end
      M_DELAY: begin
        if (iomem_valid && !iomem_ready) begin
          resp_cnt <= resp_cnt + 1;
          if (resp_cnt == resp_delay - 2) begin
            iomem_ready <= 1'b1;
            iomem_rdata <= DELAY_RDATA;
          end
        end
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          mode;
    int          delay;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_vcyc;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs[10];

  // One full transaction: accept, watch the bus phase, check and take the response.
  task automatic run_txn(input vec_t v, input int idx);
    int  vcyc;
    int  guard;
    logic bad;
    resp_mode  = v.mode;
    resp_delay = v.delay;
    @(negedge clk);
    check($sformatf("v%0d cmd_ready_idle", idx), 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_wstrb = v.wstrb;
    @(negedge clk);
    // Fields change after acceptance; the bus must keep the accepted ones.
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom_range(0, 15));
    vcyc  = 0;
    guard = 0;
    bad   = 1'b0;
    while (iomem_valid && guard < 40) begin
      vcyc++;
      guard++;
      if (iomem_addr !== v.addr || iomem_wdata !== v.wdata || iomem_wstrb !== v.wstrb ||
          cmd_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    check($sformatf("v%0d bus_stable", idx), 32'(bad), 32'd0);
    check($sformatf("v%0d valid_cycles", idx), 32'(vcyc), 32'(v.exp_vcyc));
    check($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
    check($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
    check($sformatf("v%0d gpio_reg", idx), gpio_reg, v.exp_reg);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d rsp_done", idx), {busy, rsp_valid, cmd_ready}, 32'b001);
  endtask

  initial begin
    logic [31:0] held_rdata;
    logic        bad;
    int          guard;

    vecs[0] = '{32'h0300_0000, 32'h1234_5678, 4'hF, M_GPIO,  2, 32'h0000_0000, 1'b0, 2, 32'h1234_5678};
    vecs[1] = '{32'h0300_0000, 32'h0000_0000, 4'h0, M_GPIO,  2, 32'h1234_5678, 1'b0, 2, 32'h1234_5678};
    vecs[2] = '{32'h0300_0010, 32'hAABB_CCDD, 4'h2, M_GPIO,  2, 32'h1234_5678, 1'b0, 2, 32'h1234_CC78};
    vecs[3] = '{32'h0300_0000, 32'h0000_0000, 4'h0, M_GPIO,  2, 32'h1234_CC78, 1'b0, 2, 32'h1234_CC78};
    vecs[4] = '{32'h0300_0000, 32'h55AA_55AA, 4'h9, M_GPIO,  2, 32'h1234_CC78, 1'b0, 2, 32'h5534_CCAA};
    vecs[5] = '{32'h0400_0000, 32'h0000_0000, 4'h0, M_GPIO,  2, 32'h0000_0000, 1'b1, 8, 32'h5534_CCAA};
    vecs[6] = '{32'h0300_0000, 32'h0000_0000, 4'h0, M_NEVER, 2, 32'h0000_0000, 1'b1, 8, 32'h5534_CCAA};
    vecs[7] = '{32'h0300_0000, 32'h0000_0000, 4'h0, M_DELAY, 8, DELAY_RDATA,   1'b0, 8, 32'h5534_CCAA};
    vecs[8] = '{32'h0300_0000, 32'h0000_0000, 4'h0, M_DELAY, 3, DELAY_RDATA,   1'b0, 3, 32'h5534_CCAA};
    vecs[9] = '{32'h0300_0004, 32'hFFFF_FFFF, 4'hF, M_DELAY, 7, DELAY_RDATA,   1'b0, 7, 32'h5534_CCAA};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs", {30'(0), iomem_valid, rsp_valid}, 32'd0);
    check("reset_err_busy_ready", {29'(0), rsp_err, busy, cmd_ready}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_addr", iomem_addr, 32'd0);
    check("reset_wdata_strb", {iomem_wdata[27:0], iomem_wstrb}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_txn(vecs[i], i);

    // Response back-pressure with cmd_valid held high throughout.
    resp_mode = M_GPIO;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0300_0000;
    cmd_wdata = 32'h0;
    cmd_wstrb = 4'h0;
    @(negedge clk);
    cmd_wdata = 32'hDEAD_BEEF;
    cmd_wstrb = 4'hF;
    guard = 0;
    while (iomem_valid && guard < 40) begin
      guard++;
      @(negedge clk);
    end
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_rdata", rsp_rdata, 32'h5534_CCAA);
    held_rdata = rsp_rdata;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== held_rdata || rsp_err !== 1'b0 ||
          cmd_ready !== 1'b0 || iomem_valid !== 1'b0) bad = 1'b1;
    end
    check("bp_hold_stable", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_after_handshake", {iomem_valid, rsp_valid, cmd_ready}, 32'b001);
    cmd_valid = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (iomem_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("bp_no_second_txn", 32'(bad), 32'd0);
    check("bp_reg_untouched", gpio_reg, 32'h5534_CCAA);

    // Reset in the middle of a bus phase.
    resp_mode = M_NEVER;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0300_0000;
    cmd_wdata = 32'h0BAD_0BAD;
    cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_bus_valid_before", 32'(iomem_valid), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("rst_mid_valid_busy", {iomem_valid, busy, rsp_valid}, 32'd0);
    check("rst_mid_addr", iomem_addr, 32'd0);
    bad = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || iomem_valid !== 1'b0) bad = 1'b1;
    end
    check("rst_no_response", 32'(bad), 32'd0);
    run_txn('{32'h0300_0000, 32'h0, 4'h0, M_GPIO, 2, 32'h5534_CCAA, 1'b0, 2, 32'h5534_CCAA}, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iomem_initiator.md
IOMEM_INITIATOR -- requirements
Module: iomem_initiator

Interface
REQ-001 Parameter TIMEOUT, 255, max cycles iomem_valid stays high awaiting iomem_ready; 0 disables timeout.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 cmd_addr  input  32  target address.
REQ-007 cmd_wdata  input  32  write data.
REQ-008 cmd_wstrb  input  4  byte write enables; 0 = read.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-011 rsp_rdata  output  32  read data (0 on error).
REQ-012 rsp_err  output  1  transaction timed out.
REQ-013 iomem_valid  output  1  bus request to responder.
REQ-014 iomem_ready  input  1  responder completion strobe.
REQ-015 iomem_addr / iomem_wdata  output  32 each  bus address / write data.
REQ-016 iomem_wstrb  output  4  bus byte enables.
REQ-017 iomem_rdata  input  32  responder read data.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, BUS, RESP; exactly one transaction outstanding.
REQ-020 IDLE: cmd_ready = 1 (combinational, gated low while resetn low); all other handshake outputs low.
REQ-021 cmd_valid && cmd_ready at edge N: latch addr/wdata/wstrb onto iomem_* outputs, clear timer, enter BUS; iomem_valid high from cycle N+1.
REQ-022 BUS: iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb held stable; cmd_ready low.
REQ-023 BUS, iomem_ready sampled high at an edge: capture iomem_rdata into rsp_rdata (reads and writes alike), rsp_err = 0, iomem_valid low next cycle, enter RESP.
REQ-024 Timer increments each BUS cycle; iomem_valid high for at most TIMEOUT cycles; if iomem_ready still low at the edge ending the TIMEOUT-th cycle: rsp_rdata = 0, rsp_err = 1, iomem_valid low, enter RESP.
REQ-025 iomem_ready and timeout expiry at the same edge: ready wins (rsp_err = 0).
REQ-026 Timer width clog2(TIMEOUT+1), saturating; with TIMEOUT = 0 the timer never expires.
REQ-027 RESP: rsp_valid = 1, rsp_rdata/rsp_err stable until rsp_valid && rsp_ready; then IDLE next cycle.
REQ-028 cmd_valid in BUS/RESP is ignored; command fields are sampled only at acceptance.
REQ-029 Minimum latency: command accepted edge N, ready at edge N+1, rsp_valid high cycle N+2; next command acceptable in the cycle after response handshake.
REQ-030 iomem_* address/data/strobe outputs hold last value outside BUS; meaningful only while iomem_valid is high.

Reset
REQ-031 resetn low at an edge: state IDLE, timer 0, iomem_valid 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, iomem_addr/wdata/wstrb 0, busy 0.
REQ-032 Reset in BUS or RESP abandons the transaction; no response is ever issued for it.

Structure
REQ-033 Package iomem_pkg holds the FSM state enum, bus width constants (ADDR_W = 32, DATA_W = 32, STRB_W = 4), and region constant IOMEM_GPIO_REGION = 8'h03.
REQ-034 Single flat module; no sub-module (timer and FSM are small).

Verification
REQ-035 Write 0x0300_0000, wdata 0x1234_5678, wstrb 4'hF, to a GPIO-style responder (1-cycle ready) -> iomem_valid high exactly 2 cycles; rsp_err 0; responder register = 0x1234_5678.
REQ-036 Read 0x0300_0000, wstrb 0, after the above write -> rsp_rdata 0x1234_5678, rsp_err 0.
REQ-037 TIMEOUT = 8, responder never ready -> iomem_valid high exactly 8 cycles; rsp_err 1, rsp_rdata 0.
REQ-038 TIMEOUT = 8, ready on the 8th cycle -> rsp_err 0, rdata captured.
REQ-039 rsp_ready held low 5 cycles, cmd_valid held high -> rsp_valid/rsp_rdata stable, cmd_ready 0, no second iomem_valid until after the response handshake.
REQ-040 resetn low for 1 cycle mid-BUS -> next cycle iomem_valid 0, busy 0, rsp_valid never asserts; a subsequent command completes normally.
